apb_sram_bridge: RTL

// - APB slave that converts 32-bit APB transfers into native single-port SRAM accesses
//   (req/we/addr/wdata/be -> rdata, one-cycle read latency).
// - Sits directly upstream of the SoC's wide behavioural SRAM macro.
// - Handles lane selection between APB word and wide SRAM word, byte strobes,
//   the read wait state and address error responses.

---
 rtl/apb_sram_bridge_pkg.sv | 38 +++
 rtl/apb_sram_lane_mux.sv | 29 ++
 rtl/apb_sram_bridge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/apb_sram_bridge_pkg.sv
// Shared types and width helpers for the APB-to-SRAM bridge.
package apb_sram_bridge_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    // Ceiling log2 that stays usable in localparam context.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned lane_count(input int unsigned sram_w, input int unsigned apb_w);
        return sram_w / apb_w;
    endfunction

    // Lane index needs at least one bit even when the SRAM word holds a single APB word.
    function automatic int unsigned lane_idx_width(input int unsigned lanes);
        return (lanes <= 1) ? 1 : log2c(lanes);
    endfunction

    // Byte-offset bits below the APB word.
    function automatic int unsigned lane_shift(input int unsigned apb_w);
        return log2c(apb_w / 8);
    endfunction

    // Byte-offset bits below the SRAM word.
    function automatic int unsigned word_shift(input int unsigned sram_w);
        return log2c(sram_w / 8);
    endfunction

endpackage

// File: rtl/apb_sram_lane_mux.sv
// Steers an APB word into/out of one lane of a wide SRAM word.
module apb_sram_lane_mux
    import apb_sram_bridge_pkg::*;
#(
    parameter int unsigned APB_DATA_WIDTH  = 32,
    parameter int unsigned SRAM_DATA_WIDTH = 64,
    parameter int unsigned LANE_W          = lane_idx_width(lane_count(SRAM_DATA_WIDTH, APB_DATA_WIDTH))
) (
    input  logic [LANE_W-1:0]            wr_lane,
    input  logic [APB_DATA_WIDTH/8-1:0]  strb,
    input  logic [APB_DATA_WIDTH-1:0]    apb_wdata,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_wdata,
    input  logic [LANE_W-1:0]            rd_lane,
    input  logic [SRAM_DATA_WIDTH-1:0]   sram_rdata,
    output logic [APB_DATA_WIDTH-1:0]    apb_rdata
);

    localparam int unsigned APB_BYTES  = APB_DATA_WIDTH / 8;
    localparam int unsigned SRAM_BYTES = SRAM_DATA_WIDTH / 8;
    localparam int unsigned LANES      = lane_count(SRAM_DATA_WIDTH, APB_DATA_WIDTH);

    always_comb begin
        sram_be    = SRAM_BYTES'(strb) << (32'(wr_lane) * APB_BYTES);
        sram_wdata = {LANES{apb_wdata}};
        apb_rdata  = APB_DATA_WIDTH'(sram_rdata >> (32'(rd_lane) * APB_DATA_WIDTH));
    end

endmodule

// File: rtl/apb_sram_bridge.sv
// APB slave front-end for a wide single-port SRAM: zero-wait writes, one-wait reads.
module apb_sram_bridge
    import apb_sram_bridge_pkg::*;
#(
    parameter int unsigned                 APB_ADDR_WIDTH  = 32,
    parameter int unsigned                 APB_DATA_WIDTH  = 32,
    parameter int unsigned                 SRAM_DATA_WIDTH = 64,
    parameter int unsigned                 NUM_WORDS       = 1024,
    parameter logic [APB_ADDR_WIDTH-1:0]   BASE_ADDR       = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]      paddr_i,
    input  logic                           psel_i,
    input  logic                           penable_i,
    input  logic                           pwrite_i,
    input  logic [APB_DATA_WIDTH-1:0]      pwdata_i,
    input  logic [APB_DATA_WIDTH/8-1:0]    pstrb_i,
    output logic [APB_DATA_WIDTH-1:0]      prdata_o,
    output logic                           pready_o,
    output logic                           pslverr_o,
    output logic                           req_o,
    output logic                           we_o,
    output logic [$clog2(NUM_WORDS)-1:0]   addr_o,
    output logic [SRAM_DATA_WIDTH-1:0]     wdata_o,
    output logic [SRAM_DATA_WIDTH/8-1:0]   be_o,
    input  logic [SRAM_DATA_WIDTH-1:0]     rdata_i
);

    localparam int unsigned APB_BYTES    = APB_DATA_WIDTH / 8;
    localparam int unsigned SRAM_BYTES   = SRAM_DATA_WIDTH / 8;
    localparam int unsigned LANES        = lane_count(SRAM_DATA_WIDTH, APB_DATA_WIDTH);
    localparam int unsigned LANE_W       = lane_idx_width(LANES);
    localparam int unsigned LANE_SHIFT   = lane_shift(APB_DATA_WIDTH);
    localparam int unsigned WORD_SHIFT   = word_shift(SRAM_DATA_WIDTH);
    localparam int unsigned SRAM_AW      = $clog2(NUM_WORDS);
    localparam logic [63:0] WINDOW_BYTES = 64'(NUM_WORDS) * 64'(SRAM_BYTES);

    if (SRAM_DATA_WIDTH % APB_DATA_WIDTH != 0) begin : g_chk_ratio
        $error("SRAM_DATA_WIDTH must be a multiple of APB_DATA_WIDTH");
    end
    if ((LANES & (LANES - 1)) != 0) begin : g_chk_pow2
        $error("SRAM/APB width ratio must be a power of two");
    end
    if (NUM_WORDS < 2) begin : g_chk_depth
        $error("NUM_WORDS must be at least 2");
    end

    state_e                     state_q, state_d;
    logic [LANE_W-1:0]          lane_q;
    logic [APB_ADDR_WIDTH:0]    diff;
    logic [APB_ADDR_WIDTH-1:0]  off;
    logic                       below_base;
    logic                       out_of_range;
    logic                       misaligned;
    logic                       addr_err;
    logic                       access;
    logic [LANE_W-1:0]          lane;
    logic [SRAM_AW-1:0]         word_addr;
    logic [SRAM_BYTES-1:0]      lane_be;
    logic [SRAM_DATA_WIDTH-1:0] lane_wdata;
    logic [APB_DATA_WIDTH-1:0]  lane_rdata;

    // Address decode; the borrow of the base subtraction flags addresses below the window.
    always_comb begin
        diff         = {1'b0, paddr_i} - {1'b0, BASE_ADDR};
        below_base   = diff[APB_ADDR_WIDTH];
        off          = diff[APB_ADDR_WIDTH-1:0];
        out_of_range = 64'(off) >= WINDOW_BYTES;
        misaligned   = (paddr_i & APB_ADDR_WIDTH'(APB_BYTES - 1)) != '0;
        addr_err     = below_base | out_of_range | misaligned;
        access       = psel_i & penable_i;
        word_addr    = SRAM_AW'(off >> WORD_SHIFT);
        lane         = LANE_W'((off >> LANE_SHIFT) & APB_ADDR_WIDTH'(LANES - 1));
    end

    apb_sram_lane_mux #(
        .APB_DATA_WIDTH  (APB_DATA_WIDTH),
        .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH),
        .LANE_W          (LANE_W)
    ) u_lane_mux (
        .wr_lane    (lane),
        .strb       (pstrb_i),
        .apb_wdata  (pwdata_i),
        .sram_be    (lane_be),
        .sram_wdata (lane_wdata),
        .rd_lane    (lane_q),
        .sram_rdata (rdata_i),
        .apb_rdata  (lane_rdata)
    );

    // State register; the read lane is captured alongside the read request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && access && !addr_err && !pwrite_i) begin
                lane_q <= lane;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (access && !addr_err && !pwrite_i) state_d = RD_WAIT;
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs held quiet while reset is asserted so an aborted read never completes.
    always_comb begin
        prdata_o  = '0;
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        req_o     = 1'b0;
        we_o      = 1'b0;
        addr_o    = '0;
        wdata_o   = '0;
        be_o      = '0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (addr_err) begin
                            pready_o  = 1'b1;
                            pslverr_o = 1'b1;
                        end else if (pwrite_i) begin
                            req_o    = 1'b1;
                            we_o     = 1'b1;
                            addr_o   = word_addr;
                            wdata_o  = lane_wdata;
                            be_o     = lane_be;
                            pready_o = 1'b1;
                        end else begin
                            req_o  = 1'b1;
                            addr_o = word_addr;
                        end
                    end
                end
                RD_WAIT: begin
                    if (psel_i) begin
                        pready_o = 1'b1;
                        prdata_o = lane_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
